dcs_stream_driver: RTL and testbench
====================================

Name: dcs_stream_driver

Overview:
- Host-side master for the DCSformer accelerator interface.
- Accepts a bursty byte stream from an upstream source: 128 X-matrix bytes followed by 8 weight bytes, buffered internally.
- Replays them with the exact timing the accelerator requires: X as one gap-free i_valid burst, weights only after w_ready.
- Collects the 8 32-bit results and re-emits them, indexed, on a result port.

Parameters:
- N_X, 128, number of X bytes per job; sent as one contiguous i_valid burst.
- N_W, 8, number of weight bytes per job.
- N_O, 8, number of 32-bit result words captured per job.
- TIMEOUT_CYC, 1024, cycle budget for w_ready or for result collection (used only with optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream byte.
- s_ready  out  1  upstream ready; transfer when s_valid&&s_ready.
- i_valid  out  1  X byte valid to accelerator.
- i_data  out  8  X byte to accelerator.
- w_ready  in  1  accelerator ready-for-weights pulse.
- w_valid  out  1  weight byte valid to accelerator.
- w_data  out  8  weight byte to accelerator.
- o_valid  in  1  accelerator result valid.
- o_data  in  32  accelerator result word.
- r_valid  out  1  captured result valid, one cycle per word.
- r_data  out  32  captured result word.
- r_idx  out  3  result index 0..N_O-1.
- r_last  out  1  high with r_valid on index N_O-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, job complete.
- err  out  1  one-cycle pulse on timeout; constant 0 without the optional feature.

Behaviour:
- Reset:
  - FSM returns to IDLE and byte/word counters clear.
  - All outputs go to 0 asynchronously, including s_ready, i_valid, w_valid, r_valid, done, err and busy.
  - Buffer contents are don't-care after reset.
- IDLE:
  - start=1 moves to LOAD next cycle. Otherwise the FSM stays in IDLE.
  - start is ignored in every other state.
- LOAD:
  - s_ready=1.
  - Each handshake writes buf[cnt] and increments cnt.
  - After the (N_X+N_W)th byte is accepted, s_ready drops in the following cycle and the FSM moves to SEND_X.
  - Bytes are stored in arrival order; gaps in s_valid are allowed.
- SEND_X:
  - i_valid and i_data are registered outputs.
  - i_valid is high for exactly N_X consecutive cycles, carrying i_data = buf[0..N_X-1] in order.
  - i_valid must never gap mid-burst, because the accelerator raises w_ready on the first idle cycle after i_valid.
  - After the burst, the FSM moves to WAIT_WR.
- WAIT_WR:
  - The FSM waits for w_ready=1.
  - w_ready seen during SEND_X or LOAD is ignored.
  - On the cycle w_ready is sampled high, the FSM moves to SEND_W.
  - The first w_valid is in the cycle after w_ready, never coincident with it, because the accelerator clears its accumulators on w_ready.
- SEND_W:
  - w_valid is high for exactly N_W consecutive cycles, carrying w_data = buf[N_X..N_X+N_W-1].
  - The FSM then moves to COLLECT.
- COLLECT:
  - Each cycle with o_valid=1 captures o_data.
  - The following cycle shows r_valid=1, r_data=captured word, and r_idx=capture count.
  - On index N_O-1, r_last=1; the FSM moves to DONE.
  - o_valid outside COLLECT is ignored. o_valid beyond N_O words is ignored.
- DONE:
  - done=1 for one cycle, then IDLE.
  - done is coincident with the cycle after r_last.
  - busy falls in the same cycle the FSM enters IDLE.
- Latency:
  - start to s_ready: 1 cycle.
  - Last upstream byte to first i_valid: 2 cycles.
  - w_ready to first w_valid: 1 cycle.
  - o_valid to r_valid: 1 cycle.
- Widths: counters are wide enough for N_X+N_W; r_idx wraps modulo 8 and is never exceeded with default N_O.
- Reset mid-operation: the job is abandoned and no done is issued. Upstream must restart from byte 0 after a new start.

Optional Feature:
- DCS_DRV_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_WR and COLLECT.
  - It restarts on state entry and on each captured word.
  - If it reaches TIMEOUT_CYC, err pulses for 1 cycle and the FSM returns to IDLE, with no done and no further r_valid.
- Not defined: no counter; WAIT_WR and COLLECT wait indefinitely; err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 mid-LOAD → all outputs 0 immediately; after release, busy=0 and s_ready=0 until start.
- Load with gaps: start, then 136 bytes 0x00..0x87 with random s_valid gaps → i_valid high exactly 128 consecutive cycles with i_data 0x00..0x7F, beginning 2 cycles after the last byte; w_valid stays 0.
- Weight timing: model pulses w_ready 3 cycles after i_valid falls → w_valid high for the next 8 cycles with w_data 0x80..0x87; no w_valid in the w_ready cycle.
- Result collection: model drives o_valid for 8 cycles with o_data 0x11111111..0x88888888 → r_valid for 8 cycles (1-cycle delay), r_idx 0..7, r_last on 0x88888888, done pulse next cycle, then busy=0.
- Ignored events: start pulsed during SEND_X and w_ready pulsed during LOAD → no effect; the job completes normally.
- Timeout (DCS_DRV_TIMEOUT_EN, TIMEOUT_CYC=16): w_ready never asserted → err pulses 16 cycles after WAIT_WR entry, FSM returns to IDLE, done never asserted.

Source files
------------

// File: rtl/dcs_stream_driver.sv
// rtl/dcs_stream_driver.sv - buffers one DCSformer job from a byte stream and replays it with accelerator timing
module dcs_stream_driver #(
    parameter int N_X         = 128,
    parameter int N_W         = 8,
    parameter int N_O         = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        i_valid,
    output logic [7:0]  i_data,
    input  logic        w_ready,
    output logic        w_valid,
    output logic [7:0]  w_data,
    input  logic        o_valid,
    input  logic [31:0] o_data,
    output logic        r_valid,
    output logic [31:0] r_data,
    output logic [2:0]  r_idx,
    output logic        r_last,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int N_B = N_X + N_W;
    localparam int CW  = $clog2(N_B + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND_X, WAIT_WR, SEND_W, COLLECT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    ocnt;
    logic [7:0]    mem [0:N_B-1];
    logic          timeout_hit;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (state == LOAD && s_valid && s_ready) mem[cnt] <= s_data;
    end

`ifdef DCS_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if ((state != WAIT_WR && state != COLLECT) || (state == COLLECT && o_valid)) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ocnt    <= '0;
            s_ready <= 1'b0;
            i_valid <= 1'b0;
            i_data  <= '0;
            w_valid <= 1'b0;
            w_data  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    ocnt <= '0;
                    if (start) begin
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        if (cnt == CW'(N_B - 1)) begin
                            cnt     <= '0;
                            s_ready <= 1'b0;
                            state   <= SEND_X;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SEND_X: begin
                    if (cnt == CW'(N_X)) begin
                        i_valid <= 1'b0;
                        state   <= WAIT_WR;
                    end else begin
                        i_valid <= 1'b1;
                        i_data  <= mem[cnt];
                        cnt     <= cnt + CW'(1);
                    end
                end
                WAIT_WR: begin
                    if (w_ready) begin
                        w_valid <= 1'b1;
                        w_data  <= mem[cnt];
                        cnt     <= cnt + CW'(1);
                        state   <= SEND_W;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                SEND_W: begin
                    if (cnt == CW'(N_B)) begin
                        w_valid <= 1'b0;
                        state   <= COLLECT;
                    end else begin
                        w_valid <= 1'b1;
                        w_data  <= mem[cnt];
                        cnt     <= cnt + CW'(1);
                    end
                end
                COLLECT: begin
                    if (o_valid) begin
                        r_valid <= 1'b1;
                        r_data  <= o_data;
                        r_idx   <= ocnt;
                        r_last  <= (ocnt == 3'(N_O - 1));
                        ocnt    <= ocnt + 3'd1;
                        if (ocnt == 3'(N_O - 1)) state <= DONE;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcs_stream_driver.sv
// tb/tb_dcs_stream_driver.sv - directed and table-driven checks of dcs_stream_driver job timing
module tb_dcs_stream_driver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        w_ready;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        o_valid;
    logic [31:0] o_data;
    logic        r_valid;
    logic [31:0] r_data;
    logic [2:0]  r_idx;
    logic        r_last;
    logic        busy;
    logic        done;
    logic        err;

    int total  = 0;
    int passed = 0;
    int bad_load = 0;

    always #5 clk = ~clk;

    dcs_stream_driver #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .i_valid(i_valid), .i_data(i_data),
        .w_ready(w_ready), .w_valid(w_valid), .w_data(w_data),
        .o_valid(o_valid), .o_data(o_data),
        .r_valid(r_valid), .r_data(r_data), .r_idx(r_idx), .r_last(r_last),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic        ov;
        logic [31:0] od;
        logic        e_rv;
        logic [31:0] e_rd;
        logic [2:0]  e_idx;
        logic        e_last;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vec [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic load_bytes(input bit pulse_wr);
        for (int b = 0; b < 136; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                if (i_valid || w_valid || !s_ready) bad_load++;
                step();
            end
            s_valid = 1'b1;
            s_data  = 8'(b);
            w_ready = pulse_wr && (b == 10);
            if (i_valid || w_valid || !s_ready) bad_load++;
            step();
            w_ready = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic run_x_burst(input bit pulse_start, output int bad);
        bad = 0;
        if (i_valid) bad++;
        step();
        for (int k = 0; k < 128; k++) begin
            if (!i_valid || i_data !== 8'(k)) bad++;
            start = pulse_start && (k == 5);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        w_ready = 1'b0; o_valid = 1'b0; o_data = '0;

        vec[0]  = '{1'b1, 32'h11111111, 1'b1, 32'h11111111, 3'd0, 1'b0, 1'b0, 1'b1};
        vec[1]  = '{1'b1, 32'h22222222, 1'b1, 32'h22222222, 3'd1, 1'b0, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 32'h33333333, 1'b1, 32'h33333333, 3'd2, 1'b0, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 32'h44444444, 1'b1, 32'h44444444, 3'd3, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{1'b0, 32'hCAFEF00D, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b1};
        vec[5]  = '{1'b1, 32'h55555555, 1'b1, 32'h55555555, 3'd4, 1'b0, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 32'h66666666, 1'b1, 32'h66666666, 3'd5, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 32'h77777777, 1'b1, 32'h77777777, 3'd6, 1'b0, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 32'h88888888, 1'b1, 32'h88888888, 3'd7, 1'b1, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 1'b0};
        vec[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0};

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_to_s_ready", s_ready, 1);
        chk("load_busy", busy, 1);
        for (int b = 0; b < 5; b++) begin
            s_valid = 1'b1; s_data = 8'hA0 + 8'(b);
            step();
        end
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_s_ready", s_ready, 0);
        chk("async_rst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_s_ready", s_ready, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("job_s_ready", s_ready, 1);
        load_bytes(1'b1);
        chk("quiet_during_load", bad_load, 0);
        chk("s_ready_dropped", s_ready, 0);
        run_x_burst(1'b1, bad);
        chk("x_burst_errs", bad, 0);
        chk("i_valid_after_burst", i_valid, 0);
        chk("busy_wait_wr", busy, 1);

        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (w_valid) bad++;
            step();
        end
        w_ready = 1'b1;
        chk("w_valid_in_w_ready_cycle", w_valid, 0);
        step();
        w_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!w_valid || w_data !== 8'h80 + 8'(k)) bad++;
            step();
        end
        chk("w_burst_errs", bad, 0);
        chk("w_valid_after_burst", w_valid, 0);

        for (int i = 0; i < 11; i++) begin
            o_valid = vec[i].ov;
            o_data  = vec[i].od;
            step();
            chk($sformatf("row%0d_r_valid", i), r_valid, vec[i].e_rv);
            chk($sformatf("row%0d_r_last", i), r_last, vec[i].e_last);
            chk($sformatf("row%0d_done", i), done, vec[i].e_done);
            chk($sformatf("row%0d_busy", i), busy, vec[i].e_busy);
            if (vec[i].e_rv) begin
                chk($sformatf("row%0d_r_data", i), r_data, vec[i].e_rd);
                chk($sformatf("row%0d_r_idx", i), r_idx, vec[i].e_idx);
            end
        end
        o_valid = 1'b0;
        chk("err_after_job", err, 0);

`ifdef DCS_DRV_TIMEOUT_EN
        begin
            int n;
            int seen_done;
            n = 0;
            seen_done = 0;
            start = 1'b1;
            step();
            start = 1'b0;
            load_bytes(1'b0);
            run_x_burst(1'b0, bad);
            chk("to_x_burst_errs", bad, 0);
            for (int c = 1; c <= 40 && n == 0; c++) begin
                step();
                if (done) seen_done++;
                if (err) n = c;
            end
            chk("timeout_cycles", n, 16);
            chk("timeout_busy", busy, 0);
            step();
            chk("timeout_err_pulse", err, 0);
            chk("timeout_no_done", seen_done, 0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
